// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one word-wide memory between the instruction-fetch (I) port and
//   the data (D) port. Each granted request takes three cycles:
//   IDLE (arbitrate and latch) -> ACCESS (one memory strobe) -> RESP (ack).
//   D has priority. A starvation counter forces an I grant once D has won
//   STARVE_LIMIT consecutive arbitrations while I was waiting.
//   Misaligned or out-of-range requests still run through all three states,
//   but they never strobe the memory and they return err with the ack.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   i_req/i_addr                      I read request (held until i_ack)
//   i_ack/i_rdata/i_err               I completion pulse, read data, error
//   d_req/d_we/d_addr/d_wd            D request (held until d_ack)
//   d_ack/d_rdata/d_err               D completion pulse, read data, error
//   mem_MemRead/mem_MemWrite          memory strobes (ACCESS cycle only)
//   mem_addr/mem_wd/mem_rd            memory address, write data, read data
//   busy                              arbiter is not in IDLE
module mem_arbiter #(
    parameter int MEM_BYTES    = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wd,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);
    localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        sel_d_q;     // 1 = current transaction belongs to D
    logic        we_q;
    logic        legal_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;

    logic        grant_d, grant_i, grant;
    logic [31:0] sel_addr;
    logic        sel_legal;
    logic        access_ok;

    // Arbitration is evaluated every cycle but only acted on in IDLE.
    always_comb begin
        grant_d   = d_req && !(i_req && starve_q == LIMIT);
        grant_i   = i_req && !grant_d;
        grant     = (state_q == IDLE) && (grant_d || grant_i);
        sel_addr  = grant_d ? d_addr : i_addr;
        sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (!i_req)
                    starve_d = 4'd0;
                if (grant_d) begin
                    state_d = ACCESS;
                    // With I waiting, D can only win below the limit, so this
                    // increment never passes STARVE_LIMIT.
                    if (i_req)
                        starve_d = starve_q + 4'd1;
                end else if (grant_i) begin
                    state_d  = ACCESS;
                    starve_d = 4'd0;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            sel_d_q  <= 1'b0;
            we_q     <= 1'b0;
            legal_q  <= 1'b0;
            addr_q   <= 32'd0;
            wd_q     <= 32'd0;
            i_rdata  <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (grant) begin
                sel_d_q <= grant_d;
                we_q    <= grant_d & d_we;   // I is read-only
                legal_q <= sel_legal;
                addr_q  <= sel_addr;
                wd_q    <= grant_d ? d_wd : 32'd0;
            end
            if (state_q == ACCESS && legal_q && !we_q) begin
                if (sel_d_q)
                    d_rdata <= mem_rd;
                else
                    i_rdata <= mem_rd;
            end
        end
    end

    assign access_ok    = (state_q == ACCESS) && legal_q;
    assign mem_MemRead  = access_ok && !we_q;
    // A write coinciding with a reset edge is dropped, not half-committed.
    assign mem_MemWrite = access_ok && we_q && !rst;
    assign mem_addr     = addr_q;
    assign mem_wd       = wd_q;

    assign i_ack = (state_q == RESP) && !sel_d_q;
    assign d_ack = (state_q == RESP) &&  sel_d_q;
    assign i_err = i_ack && !legal_q;
    assign d_err = d_ack && !legal_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter: a table of directed D transactions, hand-written
//   sequences for priority, starvation, reset abort and idle, then a random
//   run checked against a timestamp-based transaction model.
module tb_mem_arbiter;

    localparam int MEM_BYTES = 1024;
    localparam int STARVE    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_ack, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = 32'd0, d_wd = 32'd0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        mem_MemRead, mem_MemWrite;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        busy;

    mem_arbiter #(.MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural word memory with a bench-side preload port.
    logic [31:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_wa = 8'd0;
    logic [31:0] tb_wd = 32'd0;
    always @(posedge clk) begin
        if (mem_MemWrite)
            mem[mem_addr[9:2]] <= mem_wd;
        else if (tb_we)
            mem[tb_wa] <= tb_wd;
    end
    assign mem_rd = mem[mem_addr[9:2]];

    int rd_cnt = 0, wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_MemRead)  rd_cnt <= rd_cnt + 1;
        if (mem_MemWrite) wr_cnt <= wr_cnt + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One D transaction; lat = cycles from first edge to ack (-1 on timeout).
    task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wd = wd;
        lat = -1; err = 1'b0; rd = 32'd0;
        for (int n = 1; n <= 10; n++) begin
            tick;
            if (d_ack) begin
                lat = n; err = d_err; rd = d_rdata;
                break;
            end
        end
        d_req = 1'b0;
        tick;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return 32'($urandom_range(0, 255)) << 2;
        else if (r < 9) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        else            return 32'h400 + (32'($urandom_range(0, 63)) << 2);
    endfunction

    function automatic bit is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a <= 32'(MEM_BYTES - 4));
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_nrd;
        int          e_nwr;
    } vec_t;

    vec_t        vecs[8];
    int          lat, rd0, wr0, dt, it, dcnt, iacks, first_d, second_d;
    logic        err;
    logic [31:0] rd, drd, ird;

    // Random-phase reference model state.
    logic [31:0] ref_mem [256];
    int          free_edge, starve, g_edge;
    bit          g_valid, g_isd, g_we, g_legal, gd, gi, ea_i, ea_d;
    logic [31:0] g_addr, g_wd, g_rdata, exp_ird, exp_drd;
    bit          ir_act, dr_act, dr_we;
    logic [31:0] ir_addr, dr_addr, dr_wd;
    int          nbad;

    initial begin
        #2_000_000;
        $display("FAIL timeout act=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        0, 1};
        vecs[1] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1, 0};
        vecs[2] = '{1'b0, 32'h06,  32'h0,        1'b1, 32'hDEADBEEF, 0, 0};
        vecs[3] = '{1'b0, 32'h3FE, 32'h0,        1'b1, 32'hDEADBEEF, 0, 0};
        vecs[4] = '{1'b1, 32'h3FC, 32'h12345678, 1'b0, 32'hDEADBEEF, 0, 1};
        vecs[5] = '{1'b0, 32'h3FC, 32'h0,        1'b0, 32'h12345678, 1, 0};
        vecs[6] = '{1'b1, 32'h400, 32'h0BADF00D, 1'b1, 32'h12345678, 0, 0};
        vecs[7] = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1, 0};

        // Preload memory while reset is held.
        for (int i = 0; i < 256; i++) begin
            tb_we = 1'b1; tb_wa = 8'(i); tb_wd = (32'(i) * 32'h01010101) ^ 32'h5A5A5A5A;
            tick;
        end
        tb_we = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_i_err", i_err, 0);
        chk("rst_d_err", d_err, 0);
        chk("rst_memread", mem_MemRead, 0);
        chk("rst_memwrite", mem_MemWrite, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        tick;

        // Directed D transactions from the table.
        foreach (vecs[k]) begin
            rd0 = rd_cnt; wr0 = wr_cnt;
            d_txn(vecs[k].we, vecs[k].addr, vecs[k].wd, lat, err, rd);
            chk($sformatf("vec%0d_latency", k), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_err", k), err, vecs[k].e_err);
            chk($sformatf("vec%0d_rdata", k), rd, vecs[k].e_rd);
            chk($sformatf("vec%0d_rd_pulses", k), 32'(rd_cnt - rd0), 32'(vecs[k].e_nrd));
            chk($sformatf("vec%0d_wr_pulses", k), 32'(wr_cnt - wr0), 32'(vecs[k].e_nwr));
        end

        // Simultaneous requests: D first, I in the following IDLE.
        d_txn(1'b1, 32'h40, 32'hCAFEF00D, lat, err, rd);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        i_req = 1'b1; i_addr = 32'h40;
        dt = -1; it = -1; drd = 32'd0; ird = 32'd0;
        for (int n = 1; n <= 12; n++) begin
            tick;
            if (d_ack && dt < 0) begin dt = n; drd = d_rdata; d_req = 1'b0; end
            if (i_ack && it < 0) begin it = n; ird = i_rdata; i_req = 1'b0; end
        end
        chk("both_d_ack_cycle", 32'(dt), 32'd2);
        chk("both_i_ack_cycle", 32'(it), 32'd5);
        chk("both_d_rdata", drd, 32'hDEADBEEF);
        chk("both_i_rdata", ird, 32'hCAFEF00D);

        // Starvation: I held, D back-to-back; I must win every 5th arbitration.
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        dcnt = 0; iacks = 0; first_d = -1; second_d = -1;
        for (int n = 1; n <= 60; n++) begin
            tick;
            if (d_ack) dcnt++;
            if (i_ack) begin
                iacks++;
                if (iacks == 1) first_d = dcnt;
                else if (iacks == 2) second_d = dcnt - first_d;
            end
            if (iacks == 2) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) tick;
        chk("starve_i_acks", 32'(iacks), 32'd2);
        chk("starve_d_before_i1", 32'(first_d), 32'd4);
        chk("starve_d_before_i2", 32'(second_d), 32'd4);

        // Reset during the ACCESS cycle of a write.
        d_txn(1'b1, 32'h20, 32'h11112222, lat, err, rd);
        wr0 = wr_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wd = 32'h99999999;
        tick;
        chk("abort_write_strobe_before_rst", mem_MemWrite, 1);
        rst = 1'b1;
        #1;
        chk("abort_write_strobe_in_rst", mem_MemWrite, 0);
        d_req = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        chk("abort_wr_pulses", 32'(wr_cnt - wr0), 32'd0);
        chk("abort_outputs", {30'd0, busy, i_ack | d_ack | i_err | d_err | mem_MemRead | mem_MemWrite}, 32'd0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_wd", mem_wd, 0);
        chk("abort_d_rdata", d_rdata, 0);
        chk("abort_i_rdata", i_rdata, 0);
        dcnt = 0;
        for (int n = 0; n < 4; n++) begin
            tick;
            if (d_ack) dcnt++;
        end
        chk("abort_no_ack", 32'(dcnt), 32'd0);
        d_txn(1'b0, 32'h20, 32'h0, lat, err, rd);
        chk("abort_mem_kept", rd, 32'h11112222);

        // Idle with no requests.
        for (int n = 0; n < 10; n++) begin
            tick;
            chk($sformatf("idle_%0d", n),
                {27'd0, busy, mem_MemRead, mem_MemWrite, i_ack, d_ack}, 32'd0);
        end

        // Random traffic against the transaction model.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ref_mem = mem;
        free_edge = 0; starve = 0; g_valid = 0; g_edge = 0;
        g_isd = 0; g_we = 0; g_legal = 0; g_addr = 0; g_wd = 0; g_rdata = 0;
        exp_ird = 0; exp_drd = 0; ea_i = 0; ea_d = 0;
        ir_act = 0; dr_act = 0; dr_we = 0; ir_addr = 0; dr_addr = 0; dr_wd = 0;
        for (int e = 0; e < 3000; e++) begin
            if (ea_i) ir_act = 0;
            if (ea_d) dr_act = 0;
            if (!ir_act && $urandom_range(0, 99) < 40) begin
                ir_act = 1; ir_addr = rand_addr();
            end
            if (!dr_act && $urandom_range(0, 99) < 60) begin
                dr_act = 1; dr_we = 1'($urandom_range(0, 1));
                dr_addr = rand_addr(); dr_wd = $urandom();
            end
            i_req = ir_act; i_addr = ir_addr;
            d_req = dr_act; d_we = dr_we; d_addr = dr_addr; d_wd = dr_wd;

            @(posedge clk);
            // Arbitration is possible only once the previous access has fully
            // retired, i.e. three edges after its grant.
            gd = 0; gi = 0;
            if (e >= free_edge) begin
                if (!ir_act) starve = 0;
                if (dr_act && !(ir_act && starve == STARVE)) begin
                    gd = 1;
                    if (ir_act && starve < STARVE) starve++;
                end else if (ir_act) begin
                    gi = 1;
                    starve = 0;
                end
                if (gd || gi) begin
                    g_valid = 1; g_edge = e; g_isd = gd;
                    g_we    = gd ? dr_we : 1'b0;
                    g_addr  = gd ? dr_addr : ir_addr;
                    g_wd    = dr_wd;
                    g_legal = is_legal(g_addr);
                    if (g_legal) begin
                        if (g_we) ref_mem[g_addr / 4] = g_wd;
                        else      g_rdata = ref_mem[g_addr / 4];
                    end
                    free_edge = e + 3;
                end
            end
            if (g_valid && e == g_edge + 1 && g_legal && !g_we) begin
                if (g_isd) exp_drd = g_rdata;
                else       exp_ird = g_rdata;
            end

            #1;
            ea_i = g_valid && e == g_edge + 1 && !g_isd;
            ea_d = g_valid && e == g_edge + 1 &&  g_isd;
            chk("rnd_i_ack", i_ack, ea_i);
            chk("rnd_d_ack", d_ack, ea_d);
            if (ea_i) chk("rnd_i_err", i_err, !g_legal);
            if (ea_d) chk("rnd_d_err", d_err, !g_legal);
            chk("rnd_i_rdata", i_rdata, exp_ird);
            chk("rnd_d_rdata", d_rdata, exp_drd);
            chk("rnd_strobes", {30'd0, mem_MemRead, mem_MemWrite},
                {30'd0, g_valid && e == g_edge && g_legal && !g_we,
                        g_valid && e == g_edge && g_legal &&  g_we});
            if (g_valid && e == g_edge && g_legal) begin
                chk("rnd_mem_addr", mem_addr, g_addr);
                if (g_we) chk("rnd_mem_wd", mem_wd, g_wd);
            end
            chk("rnd_busy", busy, g_valid && (e == g_edge || e == g_edge + 1));
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (4) tick;
        nbad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) nbad++;
        chk("rnd_mem_contents_bad_words", 32'(nbad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
